// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units:
// FSM state encoding and the counter-width helper.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to count 0..value-1; never less than one.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_add_sub_unit_fa_cell.sv
// Combinational 1-bit full adder used as the single arithmetic cell
// of the bit-serial adder/subtractor.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_sub_unit.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// LSB first, one bit per clock, with a one-cycle done strobe.
module serial_add_sub_unit
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   localparam int             CW   = clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum_out;
   logic             r_cout;

   logic             w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_sum_next;

   fa_cell u_fa (
      .a  (r_a[0]),
      .b  (r_b[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // New bit enters at the MSB so that after WIDTH shifts the LSB sits at bit 0.
   assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};

   // FSM, datapath shift registers and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_sum     <= '0;
         r_carry   <= 1'b0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sum_out <= '0;
         r_cout    <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  // Subtraction as a + ~b + !borrow_in.
                  r_a     <= a_in;
                  r_b     <= sub ? ~b_in : b_in;
                  r_carry <= cin ^ sub;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_sum   <= w_sum_next;
               r_a     <= {1'b0, r_a[WIDTH-1:1]};
               r_b     <= {1'b0, r_b[WIDTH-1:1]};
               r_carry <= w_co;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_sum_out <= w_sum_next;
                  r_cout    <= w_co;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign sum_out = r_sum_out;
   assign cout    = r_cout;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Directed and randomised checks of serial_add_sub_unit at WIDTH=8:
// results, latency, start-while-busy, mid-run reset and back-to-back use.
module tb_serial_add_sub_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout;

   int n_tests = 0;
   int n_fail  = 0;

   serial_add_sub_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .sub     (sub),
      .a_in    (a_in),
      .b_in    (b_in),
      .cin     (cin),
      .busy    (busy),
      .done    (done),
      .sum_out (sum_out),
      .cout    (cout)
   );

   always #5 clk = ~clk;

   // Reference: {cout, sum} from plain integer arithmetic.
   function automatic logic [W:0] model(input logic s, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic c);
      int d;
      logic [W:0] r;
      if (!s) begin
         d = int'(a) + int'(b) + int'(c);
         r = {d[W], d[W-1:0]};
      end else begin
         d = int'(a) - int'(b) - int'(c);
         r = {(d >= 0) ? 1'b1 : 1'b0, d[W-1:0]};
      end
      return r;
   endfunction

   // Called just after a clock edge; start is accepted at the next edge.
   // lat counts edges from the accepting edge up to the one that raises done.
   task automatic op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic c, output logic [W-1:0] r_sum, output logic r_c,
                     output int lat);
      sub = s; a_in = a; b_in = b; cin = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c; sub = ~s;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      r_sum = sum_out;
      r_c   = cout;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, sum_out, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, want all 0",
                  busy, done, sum_out, cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_add();
      logic [W-1:0] s; logic c; int lat;
      @(posedge clk); #1;
      op(1'b0, 8'h0F, 8'h01, 1'b0, s, c, lat);
      n_tests++;
      if (lat !== 9) begin n_fail++; $display("FAIL add_latency: got %0d want 9", lat); end
      n_tests++;
      if ({c, s} !== {1'b0, 8'h10}) begin
         n_fail++; $display("FAIL add_0f_01: got cout=%b sum=%h want 0 10", c, s);
      end
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || sum_out !== 8'h10) begin
         n_fail++; $display("FAIL done_one_cycle: done=%b sum=%h want 0 10", done, sum_out);
      end
      op(1'b0, 8'hFF, 8'h01, 1'b1, s, c, lat);
      n_tests++;
      if ({c, s} !== {1'b1, 8'h01}) begin
         n_fail++; $display("FAIL add_ff_01_c1: got cout=%b sum=%h want 1 01", c, s);
      end
   endtask

   task automatic test_sub();
      logic [W-1:0] s; logic c; int lat;
      @(posedge clk); #1;
      op(1'b1, 8'h05, 8'h03, 1'b0, s, c, lat);
      n_tests++;
      if ({c, s} !== {1'b1, 8'h02}) begin
         n_fail++; $display("FAIL sub_05_03: got cout=%b sum=%h want 1 02", c, s);
      end
      @(posedge clk); #1;
      op(1'b1, 8'h03, 8'h05, 1'b1, s, c, lat);
      n_tests++;
      if ({c, s} !== {1'b0, 8'hFD}) begin
         n_fail++; $display("FAIL sub_03_05_b1: got cout=%b sum=%h want 0 fd", c, s);
      end
      n_tests++;
      if (lat !== 9) begin n_fail++; $display("FAIL sub_latency: got %0d want 9", lat); end
   endtask

   task automatic test_ignore_start();
      logic [W-1:0] prev; int lat;
      @(posedge clk); #1;
      prev = sum_out;
      sub = 1'b0; a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      sub = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || sum_out !== prev) begin
         n_fail++;
         $display("FAIL run_hold: busy=%b sum=%h want 1 %h", busy, sum_out, prev);
      end
      lat = 5;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      n_tests++;
      if (lat !== 9 || {cout, sum_out} !== {1'b0, 8'h46}) begin
         n_fail++;
         $display("FAIL ignore_start: lat=%0d cout=%b sum=%h want 9 0 46", lat, cout, sum_out);
      end
   endtask

   task automatic test_midrun_reset();
      logic [W-1:0] s; logic c; int lat; int seen;
      @(posedge clk); #1;
      sub = 1'b0; a_in = 8'h77; b_in = 8'h11; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, done, sum_out, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b want all 0",
                  busy, done, sum_out, cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      n_tests++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL no_done_after_abort: active cycles=%0d want 0", seen);
      end
      op(1'b1, 8'h80, 8'h01, 1'b0, s, c, lat);
      n_tests++;
      if (lat !== 9 || {c, s} !== {1'b1, 8'h7F}) begin
         n_fail++;
         $display("FAIL after_abort: lat=%0d cout=%b sum=%h want 9 1 7f", lat, c, s);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] s; logic c; int lat;
      logic [W-1:0] a; logic [W-1:0] b; logic sb; logic ci; logic [W:0] exp;
      @(posedge clk); #1;
      for (int i = 0; i < 1000; i++) begin
         a  = W'($urandom_range(0, 255));
         b  = W'($urandom_range(0, 255));
         sb = 1'($urandom_range(0, 1));
         ci = 1'($urandom_range(0, 1));
         if (i == 0) begin a = 8'hFF; b = 8'hFF; sb = 1'b0; ci = 1'b1; end
         if (i == 1) begin a = 8'h00; b = 8'hFF; sb = 1'b1; ci = 1'b1; end
         exp = model(sb, a, b, ci);
         op(sb, a, b, ci, s, c, lat);
         n_tests++;
         if (lat !== 9) begin
            n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want 9", i, lat);
         end
         n_tests++;
         if ({c, s} !== exp) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: sub=%b a=%h b=%h cin=%b got %b_%h want %b_%h",
                     i, sb, a, b, ci, c, s, exp[W], exp[W-1:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_ignore_start();
      test_midrun_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
